decode_issue_cycle: RTL and testbench

- Stage directly downstream of the fetch stage.
- Accepts the 18-bit fetched word {opcode[7:0], operand[9:0]} through a valid/ready handshake and decodes the opcode class.
- Expands repeated MAC instructions into a sequence of micro-ops with incrementing addresses.
- Issues each micro-op to the NLP execute datapath (embedding load, MAC array, softmax, activation, store) through a second valid/ready handshake.

---
 rtl/decode_issue_cycle_pkg.sv | 40 ++++
 rtl/decode_issue_cycle_uop_sequencer.sv | 35 +++
 rtl/decode_issue_cycle.sv | 113 +++++++++++
 tb/tb_decode_issue_cycle.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_cycle_pkg.sv
// Shared encodings and field slices for the decode/issue stage.
// Fetched word layout: {opcode[7:0], operand[9:0]}.
package decode_issue_cycle_pkg;

  localparam int OP_W   = 8;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int FW_W   = OP_W + ADDR_W;
  localparam int CLS_W  = 3;
  localparam int REP_W  = OP_W - CLS_W;

  localparam int OPCODE_MSB  = FW_W - 1;
  localparam int OPCODE_LSB  = ADDR_W;
  localparam int OPERAND_MSB = ADDR_W - 1;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [CLS_W-1:0] {
    CLS_NOP      = 3'd0,
    CLS_LOAD_EMB = 3'd1,
    CLS_MAC      = 3'd2,
    CLS_SOFTMAX  = 3'd3,
    CLS_ACT      = 3'd4,
    CLS_STORE    = 3'd5,
    CLS_RSVD     = 3'd6,
    CLS_HALT     = 3'd7
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  // Only MAC repeats; every other class issues exactly one micro-op.
  function automatic logic [REP_W-1:0] rep_of(input logic [OP_W-1:0] op);
    return (op[OP_W-1 -: CLS_W] == CLS_MAC) ? op[REP_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/decode_issue_cycle_uop_sequencer.sv
// Micro-op expansion: remaining-repeat down-counter plus wrapping address.
module uop_sequencer
  import decode_issue_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [REP_W-1:0]  rep_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last
);

  logic [REP_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;

  // Address increment relies on natural modulo-2^ADDR_W wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      addr_q <= '0;
    end else if (load) begin
      rem_q  <= rep_in;
      addr_q <= addr_in;
    end else if (step) begin
      rem_q  <= rem_q - 1'b1;
      addr_q <= addr_q + 1'b1;
    end
  end

  assign addr_out = addr_q;
  assign last     = (rem_q == '0);

endmodule

// File: rtl/decode_issue_cycle.sv
// Decode/issue stage: accepts fetched words, expands MAC repeats, and
// issues micro-ops to the execute datapath.
module decode_issue_cycle
  import decode_issue_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FW_W-1:0]   fw_data,
  input  logic              fw_valid,
  output logic              fw_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [CLS_W-1:0]  ex_class,
  output logic [ADDR_W-1:0] ex_addr,
  output logic              ex_last,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  uop_cnt
);

  state_e            state_q, state_d;
  logic [FW_W-1:0]   ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seq_load, seq_step, seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic [OP_W-1:0]   opcode;
  cls_e              cls;

  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign cls    = cls_e'(opcode[OP_W-1 -: CLS_W]);

  uop_sequencer u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (seq_load),
    .step     (seq_step),
    .rep_in   (rep_of(opcode)),
    .addr_in  (ir_q[OPERAND_MSB:OPERAND_LSB]),
    .addr_out (seq_addr),
    .last     (seq_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    seq_load  = 1'b0;
    seq_step  = 1'b0;
    fw_ready  = 1'b0;
    ex_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fw_ready = 1'b1;
        if (fw_valid) begin
          ir_d    = fw_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_NOP:  state_d = ST_IDLE;
          CLS_RSVD: begin
            illegal_d = 1'b1;
            state_d   = ST_IDLE;
          end
          CLS_HALT: state_d = ST_HALT;
          default: begin
            seq_load = 1'b1;
            state_d  = ST_ISSUE;
          end
        endcase
      end
      ST_ISSUE: begin
        ex_valid = 1'b1;
        if (ex_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (seq_last) state_d  = ST_IDLE;
          else          seq_step = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Class comes straight from the latched opcode; last is qualified so it
  // reads 0 outside ISSUE (the idle counter sits at zero).
  assign ex_class = opcode[OP_W-1 -: CLS_W];
  assign ex_addr  = seq_addr;
  assign ex_last  = (state_q == ST_ISSUE) && seq_last;
  assign busy     = (state_q == ST_DECODE) || (state_q == ST_ISSUE);
  assign halted   = (state_q == ST_HALT);
  assign illegal  = illegal_q;
  assign uop_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_issue_cycle.sv
// Directed bench for decode_issue_cycle with a micro-op scoreboard.
module tb_decode_issue_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] fw_data = '0;
  logic        fw_valid = 1'b0;
  logic        fw_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [2:0]  ex_class;
  logic [9:0]  ex_addr;
  logic        ex_last;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] uop_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] cls;
    logic [9:0] addr;
    logic       last;
  } uop_t;

  uop_t exp_q[$];
  logic stall_q = 1'b0;
  uop_t stall_v;
  uop_t act;

  decode_issue_cycle dut (
    .clk      (clk),
    .rst      (rst),
    .fw_data  (fw_data),
    .fw_valid (fw_valid),
    .fw_ready (fw_ready),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_class (ex_class),
    .ex_addr  (ex_addr),
    .ex_last  (ex_last),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal),
    .uop_cnt  (uop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_expect(input logic [17:0] w);
    logic [2:0] c;
    int rep;
    uop_t u;
    c   = w[17:15];
    rep = (c == 3'd2) ? int'(w[14:10]) : 0;
    if (c == 3'd0 || c == 3'd6 || c == 3'd7) return;
    for (int i = 0; i <= rep; i++) begin
      u.cls  = c;
      u.addr = 10'(int'(w[9:0]) + i);
      u.last = (i == rep);
      exp_q.push_back(u);
    end
  endfunction

  // Monitor: every handshake pops the scoreboard; stalls must hold outputs.
  always @(negedge clk) begin
    act = {ex_class, ex_addr, ex_last};
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      chk("ready_valid_exclusive", {31'd0, fw_ready & ex_valid}, 32'd0);
      if (stall_q) begin
        chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        chk("stall_uop", {18'd0, act}, {18'd0, stall_v});
      end
      if (ex_valid && ex_ready) begin
        chk("uop_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("uop", {18'd0, act}, {18'd0, exp_q.pop_front()});
      end
      stall_q = ex_valid && !ex_ready;
      stall_v = act;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_word(input logic [17:0] w);
    int n;
    n = 0;
    push_expect(w);
    fw_data  = w;
    fw_valid = 1'b1;
    while (!fw_ready && n < 50) begin
      step();
      n++;
    end
    chk("fw_accept", {31'd0, fw_ready}, 32'd1);
    step();
    fw_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !ex_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain", {31'd0, exp_q.size() == 0 && !ex_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_fw_ready", {31'd0, fw_ready}, 32'd1);
    chk("rst_issue", {17'd0, ex_valid, ex_class, ex_addr, ex_last}, 32'd0);
    chk("rst_flags", {29'd0, busy, halted, illegal}, 32'd0);
    chk("rst_uop_cnt", {16'd0, uop_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // 1: single LOAD_EMB, latency and return of fw_ready
    ex_ready = 1'b1;
    send_word(18'b001_00000_0000000101);
    chk("t1_decode_no_valid", {30'd0, ex_valid, busy}, 32'b01);
    chk("t1_decode_fw_ready", {31'd0, fw_ready}, 32'd0);
    step();
    chk("t1_issue", {17'd0, ex_valid, ex_class, ex_addr, ex_last},
        {17'd0, 1'b1, 3'd1, 10'd5, 1'b1});
    step();
    chk("t1_fw_ready_back", {31'd0, fw_ready}, 32'd1);
    chk("t1_uop_cnt", {16'd0, uop_cnt}, 32'd1);

    // 2: MAC rep=3 across the address wrap, back-to-back issue
    send_word({3'd2, 5'd3, 10'd1022});
    step();
    chk("t2_uop0", {18'd0, ex_valid, ex_addr, ex_last}, {18'd0, 1'b1, 10'd1022, 1'b0});
    step();
    chk("t2_uop1", {18'd0, ex_valid, ex_addr, ex_last}, {18'd0, 1'b1, 10'd1023, 1'b0});
    step();
    chk("t2_uop2", {18'd0, ex_valid, ex_addr, ex_last}, {18'd0, 1'b1, 10'd0, 1'b0});
    step();
    chk("t2_uop3", {18'd0, ex_valid, ex_addr, ex_last}, {18'd0, 1'b1, 10'd1, 1'b1});
    step();
    chk("t2_done", {30'd0, ex_valid, fw_ready}, 32'b01);
    chk("t2_uop_cnt", {16'd0, uop_cnt}, 32'd5);

    // 3: MAC rep=2 with backpressure
    ex_ready = 1'b0;
    send_word({3'd2, 5'd2, 10'd100});
    step();
    chk("t3_stalled_valid", {31'd0, ex_valid}, 32'd1);
    step(5);
    chk("t3_no_progress", {16'd0, uop_cnt}, 32'd5);
    for (int k = 0; k < 40 && !(exp_q.size() == 0 && !ex_valid); k++) begin
      ex_ready = ~ex_ready;
      step();
    end
    ex_ready = 1'b1;
    drain();
    chk("t3_uop_cnt", {16'd0, uop_cnt}, 32'd8);

    // 4: NOP, reserved, STORE
    send_word({3'd0, 5'd7, 10'd3});
    step();
    chk("t4_nop_illegal", {31'd0, illegal}, 32'd0);
    chk("t4_nop_cnt", {16'd0, uop_cnt}, 32'd8);
    send_word({3'd6, 5'd3, 10'd44});
    step();
    chk("t4_rsvd_illegal", {31'd0, illegal}, 32'd1);
    chk("t4_rsvd_cnt", {16'd0, uop_cnt}, 32'd8);
    send_word({3'd5, 5'd9, 10'd7});
    step();
    chk("t4_store", {17'd0, ex_valid, ex_class, ex_addr, ex_last},
        {17'd0, 1'b1, 3'd5, 10'd7, 1'b1});
    drain();
    chk("t4_store_cnt", {16'd0, uop_cnt}, 32'd9);
    chk("t4_illegal_sticky", {31'd0, illegal}, 32'd1);

    // 5: HALT ignores further words until reset
    send_word({3'd7, 5'd0, 10'd0});
    step();
    chk("t5_halted", {28'd0, halted, fw_ready, busy, ex_valid}, 32'b1000);
    fw_data = {3'd1, 5'd0, 10'd11};
    repeat (3) begin
      fw_valid = 1'b1;
      step();
      fw_valid = 1'b0;
      step();
    end
    chk("t5_still_halted", {28'd0, halted, fw_ready, busy, ex_valid}, 32'b1000);
    chk("t5_cnt", {16'd0, uop_cnt}, 32'd9);
    rst = 1'b0;
    #1;
    chk("t5_rst_flags", {29'd0, halted, fw_ready, illegal}, 32'b010);
    chk("t5_rst_cnt", {16'd0, uop_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // 6: asynchronous reset during the 2nd micro-op of MAC rep=5
    ex_ready = 1'b1;
    send_word({3'd2, 5'd5, 10'd200});
    for (int k = 0; k < 20 && exp_q.size() != 5; k++) step();
    chk("t6_second_uop", {21'd0, ex_valid, ex_addr}, {21'd0, 1'b1, 10'd201});
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_drop", {19'd0, ex_valid, busy, ex_addr, ex_last}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t6_idle", {30'd0, fw_ready, busy}, 32'b10);
    chk("t6_cnt_clear", {16'd0, uop_cnt}, 32'd0);
    send_word({3'd1, 5'd0, 10'd9});
    step();
    chk("t6_load", {17'd0, ex_valid, ex_class, ex_addr, ex_last},
        {17'd0, 1'b1, 3'd1, 10'd9, 1'b1});
    drain();
    chk("t6_load_cnt", {16'd0, uop_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
